// File: rtl/spdif_encoder.sv
// S/PDIF (IEC 60958 consumer) biphase-mark encoder with a one-word holding register.
// Produces 128 cells per frame, 192 frames per block, and sticky flags for
// underrun and overrun on the sample handshake.
module spdif_encoder #(
    parameter int unsigned CLK_DIV = 4,
    parameter logic [31:0] CHSTAT  = 32'h0300_0004
) (
    input  logic        mclk,
    input  logic        rst_n,
    input  logic [31:0] sample_data,
    input  logic        sample_valid,
    output logic        sample_req,
    output logic        spdif_out,
    output logic        block_start,
    output logic        underrun,
    output logic        overrun
);

    localparam int unsigned DivW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DivW-1:0] DivMax = DivW'(CLK_DIV - 1);

    // Preamble cell patterns for a preceding line level of 0, first cell in the MSB.
    localparam logic [7:0] PreB = 8'b1110_1000;
    localparam logic [7:0] PreM = 8'b1110_0010;
    localparam logic [7:0] PreW = 8'b1110_0100;

    logic [DivW-1:0] div_cnt_q, div_cnt_d;
    logic [6:0]      cell_q, cell_d;
    logic [7:0]      frame_q, frame_d;
    logic            spdif_q, spdif_d;      // also serves as last_lvl
    logic            pre_inv_q, pre_inv_d;  // line level just before the current preamble
    logic [31:0]     hold_q, hold_d;
    logic            hold_full_q, hold_full_d;
    logic [31:0]     act_q, act_d;
    logic            req_q, req_d;
    logic            bs_q, bs_d;
    logic            ur_q, ur_d;
    logic            ovr_q, ovr_d;

    logic        tick;
    logic        frame_start;
    logic        consume;
    logic [4:0]  slot;
    logic        half;
    logic        right;
    logic [15:0] audio;
    logic        c_bit;
    logic        parity;
    logic        data_bit;
    logic [7:0]  pre_pat;
    logic [2:0]  pre_idx;
    logic        pre_pol;
    logic        next_lvl;

    assign tick        = (div_cnt_q == '0);
    assign frame_start = tick && (cell_q == 7'd0);
    assign consume     = frame_start && hold_full_q;
    assign slot        = cell_q[5:1];
    assign half        = cell_q[0];
    assign right       = cell_q[6];
    assign audio       = right ? act_q[15:0] : act_q[31:16];
    assign c_bit       = (frame_q < 8'd32) ? CHSTAT[frame_q[4:0]] : 1'b0;
    // Slots 4..30 carry only audio and C as possible ones, so even parity is their XOR.
    assign parity      = (^audio) ^ c_bit;

    // Cell/frame position counters; a cell is driven on every edge where div_cnt is 0.
    always_comb begin
        div_cnt_d = (div_cnt_q == DivMax) ? '0 : div_cnt_q + 1'b1;
        cell_d    = cell_q;
        frame_d   = frame_q;
        if (tick) begin
            cell_d = cell_q + 7'd1;
            if (cell_q == 7'd127) begin
                frame_d = (frame_q == 8'd191) ? 8'd0 : frame_q + 8'd1;
            end
        end
    end

    // Logical bit carried by the current time slot (slots 4..31).
    always_comb begin
        data_bit = 1'b0;
        if (slot >= 5'd12 && slot <= 5'd27) begin
            data_bit = audio[4'(slot - 5'd12)];
        end else if (slot == 5'd30) begin
            data_bit = c_bit;
        end else if (slot == 5'd31) begin
            data_bit = parity;
        end
    end

    // Line level for the current cell: preamble pattern or biphase-mark data.
    always_comb begin
        pre_pat = PreW;
        if (!right) begin
            pre_pat = (frame_q == 8'd0) ? PreB : PreM;
        end
        pre_idx   = {slot[1:0], half};
        // The first preamble cell samples the line level; later cells reuse the latched copy.
        pre_pol   = (cell_q[5:0] == 6'd0) ? spdif_q : pre_inv_q;
        pre_inv_d = (tick && cell_q[5:0] == 6'd0) ? spdif_q : pre_inv_q;
        if (slot < 5'd4) begin
            next_lvl = pre_pat[3'd7 - pre_idx] ^ pre_pol;
        end else if (!half) begin
            next_lvl = ~spdif_q;
        end else begin
            next_lvl = data_bit ? ~spdif_q : spdif_q;
        end
        spdif_d = tick ? next_lvl : spdif_q;
    end

    // Holding/active register handshake and sticky status flags.
    always_comb begin
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        act_d       = act_q;
        ur_d        = ur_q;
        ovr_d       = ovr_q;
        req_d       = consume;
        bs_d        = frame_start && (frame_q == 8'd0);
        if (consume) begin
            act_d       = hold_q;
            hold_full_d = 1'b0;
        end else if (frame_start) begin
            ur_d = 1'b1;
        end
        if (sample_valid) begin
            hold_d      = sample_data;
            hold_full_d = 1'b1;
            if (hold_full_q && !consume) begin
                ovr_d = 1'b1;
            end
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge mclk) begin
        if (!rst_n) begin
            div_cnt_q   <= '0;
            cell_q      <= 7'd0;
            frame_q     <= 8'd0;
            spdif_q     <= 1'b0;
            pre_inv_q   <= 1'b0;
            hold_q      <= 32'd0;
            hold_full_q <= 1'b0;
            act_q       <= 32'd0;
            req_q       <= 1'b0;
            bs_q        <= 1'b0;
            ur_q        <= 1'b0;
            ovr_q       <= 1'b0;
        end else begin
            div_cnt_q   <= div_cnt_d;
            cell_q      <= cell_d;
            frame_q     <= frame_d;
            spdif_q     <= spdif_d;
            pre_inv_q   <= pre_inv_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            act_q       <= act_d;
            req_q       <= req_d;
            bs_q        <= bs_d;
            ur_q        <= ur_d;
            ovr_q       <= ovr_d;
        end
    end

    assign spdif_out   = spdif_q;
    assign sample_req  = req_q;
    assign block_start = bs_q;
    assign underrun    = ur_q;
    assign overrun     = ovr_q;

endmodule

// File: tb/tb_spdif_encoder.sv
// Self-checking bench for spdif_encoder: captures whole frames of line cells,
// decodes them and compares against a scoreboard filled from a handshake model.
module tb_spdif_encoder;

    localparam int CD = 2;
    localparam int FrameCyc = 128 * CD;
    localparam logic [31:0] CHS = 32'h0300_0004;

    logic        mclk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] sample_data = 32'd0;
    logic        sample_valid = 1'b0;
    logic        sample_req;
    logic        spdif_out;
    logic        block_start;
    logic        underrun;
    logic        overrun;

    always #5 mclk = ~mclk;

    spdif_encoder #(
        .CLK_DIV (CD),
        .CHSTAT  (CHS)
    ) dut (
        .mclk         (mclk),
        .rst_n        (rst_n),
        .sample_data  (sample_data),
        .sample_valid (sample_valid),
        .sample_req   (sample_req),
        .spdif_out    (spdif_out),
        .block_start  (block_start),
        .underrun     (underrun),
        .overrun      (overrun)
    );

    typedef struct {
        logic [31:0] audio;
        int          frame;
        int          req;
        int          bs;
        logic        ur;
        logic        ovr;
    } exp_t;

    exp_t sb[$];

    int checks = 0;
    int errors = 0;

    // Reference model of the handshake and frame position.
    logic [31:0] m_hold;
    logic [31:0] m_act;
    logic        m_full;
    logic        m_ur;
    logic        m_ovr;
    int          m_frame;
    logic        prev_lvl;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge mclk);
        #1;
    endtask

    task automatic model_reset();
        m_hold   = 32'd0;
        m_act    = 32'd0;
        m_full   = 1'b0;
        m_ur     = 1'b0;
        m_ovr    = 1'b0;
        m_frame  = 0;
        prev_lvl = 1'b0;
    endtask

    task automatic model_write(input logic [31:0] d);
        if (m_full) m_ovr = 1'b1;
        m_hold = d;
        m_full = 1'b1;
    endtask

    function automatic logic [7:0] pre_pat(input int kind, input logic inv);
        logic [7:0] p;
        case (kind)
            0:       p = 8'b1110_1000;
            1:       p = 8'b1110_0010;
            default: p = 8'b1110_0100;
        endcase
        return inv ? ~p : p;
    endfunction

    task automatic check_reset_outputs(input string tag);
        check({tag, " spdif_out"}, {31'd0, spdif_out}, 32'd0);
        check({tag, " sample_req"}, {31'd0, sample_req}, 32'd0);
        check({tag, " block_start"}, {31'd0, block_start}, 32'd0);
        check({tag, " underrun"}, {31'd0, underrun}, 32'd0);
        check({tag, " overrun"}, {31'd0, overrun}, 32'd0);
    endtask

    // Runs one full frame starting at a frame-start edge; up to two writes at given cycles
    // (cycle 0 is the frame-start edge itself, -1 disables a write).
    task automatic run_frame(input int wc0, input logic [31:0] wd0,
                             input int wc1, input logic [31:0] wd1);
        exp_t        e;
        exp_t        got;
        logic [127:0] cells;
        int          req_cnt;
        int          bs_cnt;
        int          unstable;
        int          notrans;
        int          base;
        int          kind;
        logic        lvl_before;
        logic [7:0]  pre;
        logic [15:0] aud;
        logic [15:0] aud_exp;
        logic        aux;
        logic        c_obs;
        logic        p_obs;
        logic        c_exp;
        logic [31:0] chs_v;
        string       t;

        // Model the frame-start consume, then the writes in cycle order.
        if (m_full) begin
            m_act  = m_hold;
            m_full = 1'b0;
            e.req  = 1;
        end else begin
            m_ur  = 1'b1;
            e.req = 0;
        end
        e.audio = m_act;
        e.frame = m_frame;
        e.bs    = (m_frame == 0) ? 1 : 0;
        if (wc0 >= 0) model_write(wd0);
        if (wc1 >= 0) model_write(wd1);
        e.ur  = m_ur;
        e.ovr = m_ovr;
        sb.push_back(e);
        m_frame = (m_frame + 1) % 192;

        cells    = '0;
        req_cnt  = 0;
        bs_cnt   = 0;
        unstable = 0;
        for (int i = 0; i < FrameCyc; i++) begin
            sample_valid = (i == wc0) || (i == wc1);
            sample_data  = (i == wc1) ? wd1 : wd0;
            tick();
            if (sample_req === 1'b1) req_cnt++;
            if (block_start === 1'b1) bs_cnt++;
            if (i % CD == 0) cells[i / CD] = spdif_out;
            else if (spdif_out !== cells[i / CD]) unstable++;
        end
        sample_valid = 1'b0;

        got   = sb.pop_front();
        chs_v = CHS;
        c_exp = (got.frame < 32) ? chs_v[got.frame] : 1'b0;
        notrans = 0;
        for (int s = 0; s < 2; s++) begin
            base       = 64 * s;
            lvl_before = (s == 0) ? prev_lvl : cells[63];
            kind       = (s == 1) ? 2 : ((got.frame == 0) ? 0 : 1);
            for (int j = 0; j < 8; j++) pre[7-j] = cells[base+j];
            for (int k = 0; k < 16; k++) begin
                aud[k] = cells[base+2*(12+k)] ^ cells[base+2*(12+k)+1];
            end
            aux = 1'b0;
            for (int sl = 4; sl < 32; sl++) begin
                if (cells[base+2*sl] == cells[base+2*sl-1]) notrans++;
                if (sl < 12 || sl == 28 || sl == 29) begin
                    aux = aux | (cells[base+2*sl] ^ cells[base+2*sl+1]);
                end
            end
            c_obs   = cells[base+60] ^ cells[base+61];
            p_obs   = cells[base+62] ^ cells[base+63];
            aud_exp = (s == 0) ? got.audio[31:16] : got.audio[15:0];
            t = $sformatf("frame%0d %s", got.frame, (s == 0) ? "left" : "right");
            check({t, " preamble"}, {24'd0, pre}, {24'd0, pre_pat(kind, lvl_before)});
            check({t, " audio"}, {16'd0, aud}, {16'd0, aud_exp});
            check({t, " zero slots"}, {31'd0, aux}, 32'd0);
            check({t, " C"}, {31'd0, c_obs}, {31'd0, c_exp});
            check({t, " P"}, {31'd0, p_obs}, {31'd0, ^aud_exp ^ c_exp});
        end
        prev_lvl = cells[127];
        t = $sformatf("frame%0d", got.frame);
        check({t, " slot transitions"}, notrans, 0);
        check({t, " cell stability"}, unstable, 0);
        check({t, " sample_req pulses"}, req_cnt, got.req);
        check({t, " block_start pulses"}, bs_cnt, got.bs);
        check({t, " underrun"}, {31'd0, underrun}, {31'd0, got.ur});
        check({t, " overrun"}, {31'd0, overrun}, {31'd0, got.ovr});
    endtask

    initial begin
        model_reset();
        rst_n = 1'b0;
        repeat (10) tick();
        check_reset_outputs("reset");
        rst_n = 1'b1;

        // Frame 0 goes out with the cleared active word; the write lands in frame 1.
        run_frame(5, 32'h8000_0001, -1, 32'd0);
        run_frame(-1, 32'd0, -1, 32'd0);
        // No write before frame 2: previous word repeats, underrun stays set.
        run_frame(50, 32'h1357_9BDF, -1, 32'd0);
        // Write on the frame-start edge: old word now, new word next frame, no overrun.
        run_frame(0, 32'hCAFE_BEEF, -1, 32'd0);
        // Two writes without a consume: overrun, second word is sent.
        run_frame(10, 32'h1234_5678, 100, 32'hA5A5_0F0F);
        run_frame(-1, 32'd0, -1, 32'd0);
        // Rest of the block and the first frame of the next one.
        for (int f = 6; f <= 192; f++) begin
            run_frame(7, $urandom(), -1, 32'd0);
        end

        // Reset in the middle of the right subframe (cell 70).
        for (int i = 0; i < 70 * CD; i++) begin
            sample_valid = (i == 5);
            sample_data  = 32'h7777_8888;
            tick();
        end
        sample_valid = 1'b0;
        rst_n = 1'b0;
        repeat (3) tick();
        check_reset_outputs("midframe reset");
        rst_n = 1'b1;
        model_reset();
        run_frame(3, 32'hDEAD_0001, -1, 32'd0);
        run_frame(-1, 32'd0, -1, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
